// File: rtl/gecko_decode_scoreboard.sv
// gecko_decode_scoreboard: per-register outstanding-write counters for decode hazard stalls; `GECKO_SCOREBOARD_BYPASS_EN enables the same-cycle retire bypass on lookups
module gecko_decode_scoreboard #(
  parameter int REG_COUNT     = 32,
  parameter int ADDR_WIDTH    = $clog2(REG_COUNT),
  parameter int COUNTER_WIDTH = 2,
  parameter int RETIRE_PORTS  = 2,
  parameter int TOTAL_WIDTH   = ADDR_WIDTH + COUNTER_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic                               issue_writes,
  input  logic [ADDR_WIDTH-1:0]              issue_rd,
  input  logic                               issue_forwardable,
  input  logic [ADDR_WIDTH-1:0]              rs1_addr,
  input  logic [ADDR_WIDTH-1:0]              rs2_addr,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [1:0]                         rs1_status,
  output logic [1:0]                         rs2_status,
  output logic [1:0]                         rd_status,
  output logic                               rs1_readable,
  output logic                               rs2_readable,
  output logic [ADDR_WIDTH-1:0]              exec_saved,
  input  logic [RETIRE_PORTS-1:0]            retire_valid,
  input  logic [RETIRE_PORTS*ADDR_WIDTH-1:0] retire_addr,
  output logic [TOTAL_WIDTH-1:0]             outstanding,
  output logic                               underflow_err
);
  localparam int NW = COUNTER_WIDTH + ADDR_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] MAX = '1;
  localparam logic [1:0] VALID = 2'd0, PENDING = 2'd1, FULL = 2'd2;
  logic [COUNTER_WIDTH-1:0] cnt [REG_COUNT];
  logic [COUNTER_WIDTH-1:0] cnt_d [REG_COUNT];
  logic [COUNTER_WIDTH-1:0] view [REG_COUNT];
  logic [NW-1:0] dec [REG_COUNT];
  logic [REG_COUNT-1:0] under;
  logic [TOTAL_WIDTH-1:0] sum_d;
  logic [1:0] issue_status;
  logic fire;
  function automatic logic [1:0] status_of(input logic [COUNTER_WIDTH-1:0] c);
    return c == '0 ? VALID : c == MAX ? FULL : PENDING;
  endfunction
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      dec[i] = '0;
      for (int p = 0; p < RETIRE_PORTS; p++)
        dec[i] = dec[i] + NW'(retire_valid[p] && i != 0 &&
                              retire_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i));
`ifdef GECKO_SCOREBOARD_BYPASS_EN
      view[i] = dec[i] > NW'(cnt[i]) ? '0 : COUNTER_WIDTH'(NW'(cnt[i]) - dec[i]);
`else
      view[i] = cnt[i];
`endif
    end
  end
  assign rs1_status   = rs1_addr == '0 ? VALID : status_of(view[rs1_addr]);
  assign rs2_status   = rs2_addr == '0 ? VALID : status_of(view[rs2_addr]);
  assign rd_status    = rd_addr  == '0 ? VALID : status_of(view[rd_addr]);
  assign rs1_readable = rs1_status == VALID || rs1_addr == exec_saved;
  assign rs2_readable = rs2_status == VALID || rs2_addr == exec_saved;
  assign issue_status = issue_rd == '0 ? VALID : status_of(view[issue_rd]);
  assign issue_ready  = !(issue_writes && issue_rd != '0 && issue_status == FULL);
  assign fire         = issue_valid && issue_ready;
  // Net per-register update is done wide so an over-retire is detected before truncation.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      under[i] = dec[i] > NW'(cnt[i]) + NW'(fire && issue_writes && i != 0 && issue_rd == ADDR_WIDTH'(i));
      cnt_d[i] = under[i] ? '0 : COUNTER_WIDTH'(NW'(cnt[i]) +
                 NW'(fire && issue_writes && i != 0 && issue_rd == ADDR_WIDTH'(i)) - dec[i]);
      sum_d    = sum_d + TOTAL_WIDTH'(cnt_d[i]);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_COUNT; i++) cnt[i] <= rst ? '0 : cnt_d[i];
    outstanding   <= rst ? '0 : sum_d;
    underflow_err <= rst ? 1'b0 : underflow_err | (|under);
    exec_saved    <= rst ? '0 :
                     !(fire && issue_writes) ? exec_saved :
                     issue_forwardable ? issue_rd :
                     issue_rd == exec_saved ? '0 : exec_saved;
  end
endmodule
